// File: rtl/aes_inv_key_sched_ctrl_if.sv
// Signal bundle between the inverse key-schedule controller, its key loader,
// the combinational inverse key-step datapath and the decryption round consumer.
interface aes_inv_key_sched_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [0:127]     key_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [0:127]     dp_key;
  logic [0:31]      dp_rcon;
  logic [0:127]     dp_ko;
  logic             rk_valid;
  logic             rk_ready;
  logic [0:127]     rk_data;
  logic [CNT_W-1:0] rk_round;

  modport slave (
    input  start, key_in, dp_ko, rk_ready,
    output ready, busy, done, dp_key, dp_rcon, rk_valid, rk_data, rk_round
  );

  modport master (
    output start, key_in, dp_ko, rk_ready,
    input  ready, busy, done, dp_key, dp_rcon, rk_valid, rk_data, rk_round
  );
endinterface

// File: rtl/aes_inv_key_sched_ctrl.sv
// Walks the AES-128 decryption round keys from round NUM_ROUNDS down to 0,
// one inverse key step per accepted round key, over a valid/ready stream.
module aes_inv_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4
) (
  input logic                    clk,
  input logic                    rst,
  aes_inv_key_sched_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // RUN   | presenting round keys, advancing on each handshake
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q,    state_d;
  logic [0:127]     key_q,      key_d;
  logic [CNT_W-1:0] round_q,    round_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q,     busy_d;
  logic             ready_q,    ready_d;
  logic             done_q,     done_d;
  logic [7:0]       rc_byte;
  logic             xfer;

  assign xfer = rk_valid_q && bus.rk_ready;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    round_d    = round_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          key_d      = bus.key_in;
          round_d    = CNT_W'(NUM_ROUNDS);
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (round_q != '0) begin
            key_d   = bus.dp_ko;
            round_d = round_q - CNT_W'(1);
          end else begin
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            ready_d    = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      round_q    <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // Round 0 has no inverse step left, so its rcon is zero and dp_ko is unused.
  always_comb begin
    rc_byte = 8'h00;
    case (int'(round_q))
      1:       rc_byte = 8'h01;
      2:       rc_byte = 8'h02;
      3:       rc_byte = 8'h04;
      4:       rc_byte = 8'h08;
      5:       rc_byte = 8'h10;
      6:       rc_byte = 8'h20;
      7:       rc_byte = 8'h40;
      8:       rc_byte = 8'h80;
      9:       rc_byte = 8'h1b;
      10:      rc_byte = 8'h36;
      default: rc_byte = 8'h00;
    endcase
  end

  assign bus.dp_key   = key_q;
  assign bus.dp_rcon  = {rc_byte, 24'h000000};
  assign bus.rk_data  = key_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;

endmodule

// File: doc/aes_inv_key_sched_ctrl.md
Name: aes_inv_key_sched_ctrl

Overview:
- Sequences the combinational inverse key-step datapath (invkey_gen) to produce the AES-128 decryption round keys, round 10 down to round 0, one step per accepted key.
- Holds the current round key in a register, drives the datapath's key and rcon inputs, and captures its next-key result.
- Presents each round key to the decryption round logic over a valid/ready stream with backpressure.
- Sits between the key-load interface and the decryption round pipeline.

Parameters:
- NUM_ROUNDS, 10, number of inverse steps; legal range 1..10. Round keys NUM_ROUNDS..0 are emitted, so NUM_ROUNDS+1 keys in total.
- CNT_W, 4, width of the round counter; must hold NUM_ROUNDS.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  load request; accepted only when ready=1
- key_in  in  [0:127]  last-round (round NUM_ROUNDS) key; bit 0 is the MSB of byte 0
- ready  out  1  high in IDLE; start is accepted this cycle
- busy  out  1  high from the accept cycle+1 until the final key handshake
- dp_key  out  [0:127]  current key, to the datapath temp_key input
- dp_rcon  out  [0:31]  rcon word for the current round, to the datapath
- dp_ko  in  [0:127]  previous-round key from the datapath (combinational function of dp_key and dp_rcon)
- rk_valid  out  1  round key valid
- rk_ready  in  1  consumer accepts the round key
- rk_data  out  [0:127]  round key
- rk_round  out  [CNT_W-1:0]  round index of rk_data
- done  out  1  one-cycle pulse after the round-0 key handshake

Behaviour:
- Reset value of every output is 0 except ready=1. State goes to IDLE, and the counter and key register clear. Reset has priority over every other event, including mid-sequence; an in-flight sequence is abandoned with no done pulse.
- States: IDLE, RUN.
- IDLE to RUN on start. On the next edge: key_reg<=key_in, round<=NUM_ROUNDS, rk_valid<=1. ready deasserts and busy asserts on that edge.
- Output mapping: rk_data=key_reg, rk_round=round, dp_key=key_reg (all registered).
- dp_rcon = {RC[round], 24'h0}, with RC in bits [0:7]. RC[1..10] = 01,02,04,08,10,20,40,80,1b,36. When round=0, dp_rcon=0; the datapath output is ignored in that case.
- Handshake: a transfer occurs on an edge where rk_valid && rk_ready.
  - When rk_ready=0, rk_valid, rk_data and rk_round hold stable. The key register does not advance.
  - On a transfer with round>0: key_reg<=dp_ko, round<=round-1, rk_valid stays 1. This gives one key per cycle with rk_ready tied high.
  - On a transfer with round=0: rk_valid<=0, busy<=0, ready<=1, done<=1 for one cycle, and the state returns to IDLE.
- start while in RUN is ignored, with no effect on the sequence.
- start in the same cycle that done is high is accepted, because ready is already 1. Back-to-back sequences therefore have one idle cycle between them.
- Latency with rk_ready=1 throughout:
  - accept at cycle 0;
  - round keys NUM_ROUNDS..0 on cycles 1..NUM_ROUNDS+1;
  - done on cycle NUM_ROUNDS+2.
- The datapath has no registers. dp_ko must settle within one clock, so the critical path is key_reg → datapath → key_reg.
- The counter only decrements and never wraps below 0.
- key_in is sampled only on the accept edge. Later changes to key_in do not affect the sequence.

Test Plan:
- Single sequence, FIPS-197 data, rk_ready=1:
  - stimulus: reset, then start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - response: cycle 1 gives rk_round=10 with that key;
  - cycle 2 gives rk_round=9, ac7766f319fadc2128d12941575c006e;
  - cycle 11 gives rk_round=0, 2b7e151628aed2a6abf7158809cf4f3c;
  - done=1 on cycle 12, then ready=1.
- Backpressure: same sequence, rk_ready low for 3 cycles while round=7 is presented.
  - rk_data and rk_round stay 7/constant for 4 cycles;
  - the remaining keys still match the golden FIPS schedule;
  - done is delayed by exactly 3 cycles.
- rcon drive: on each cycle, dp_rcon[0:7] matches RC[round] (36 at round 10 … 01 at round 1), and dp_rcon=0 at round 0.
- Ignored start: pulse start with a different key on cycle 5.
  - The sequence is unchanged and completes with the original keys;
  - no second sequence starts.
- Reset mid-operation: assert rst at round 4.
  - The next cycle shows rk_valid=0, busy=0, ready=1, done=0, all data outputs 0;
  - a new start then produces the full 11-key sequence correctly.
- Back-to-back and short configuration, NUM_ROUNDS=1:
  - start is asserted again on the done cycle;
  - each sequence emits rounds 1 and 0, with done on cycle 3 after its accept.
